// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit that owns the HI/LO register pair.
// MULT/MULTU use shift-add and DIV/DIVU use restoring division. Both run on magnitudes,
// and a FIXUP cycle restores the result signs.
// MTHI/MTLO complete in a single cycle. busy covers the whole iterative operation.
module muldiv_unit #(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [4:0]       alucontrol,
    input  logic             flush,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned ITER = WIDTH / BITS_PER_CYCLE;
    localparam int unsigned CNTW = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(ITER - 1);

    localparam logic [4:0] OP_MULTU = 5'b00111;
    localparam logic [4:0] OP_MULT  = 5'b01000;
    localparam logic [4:0] OP_DIV   = 5'b01111;
    localparam logic [4:0] OP_DIVU  = 5'b10000;
    localparam logic [4:0] OP_MTHI  = 5'b10001;
    localparam logic [4:0] OP_MTLO  = 5'b10010;

    typedef enum logic [1:0] {StIdle, StRun, StFixup} state_e;

    state_e             state_q, state_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   a_q, a_d;       // |multiplicand| for mul, raw dividend for div
    logic [WIDTH-1:0]   b_q, b_d;
    logic [CNTW-1:0]    cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;   // negate product / quotient
    logic               rem_neg_q, rem_neg_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic               op_mul, op_div, op_signed;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH:0]     sum, tmp, diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign op_mul    = (alucontrol == OP_MULTU) || (alucontrol == OP_MULT);
    assign op_div    = (alucontrol == OP_DIV) || (alucontrol == OP_DIVU);
    assign op_signed = (alucontrol == OP_MULT) || (alucontrol == OP_DIV);
    assign abs_a     = (op_signed && src_a[WIDTH-1]) ? -src_a : src_a;
    assign abs_b     = (op_signed && src_b[WIDTH-1]) ? -src_b : src_b;

    // One RUN iteration: BITS_PER_CYCLE shift-add or restoring-divide sub-steps
    always_comb begin
        acc_step = acc_q;
        sum      = '0;
        tmp      = '0;
        diff     = '0;
        for (int unsigned k = 0; k < BITS_PER_CYCLE; k++) begin
            if (is_div_q) begin
                // acc = {remainder, dividend bits still to shift in / quotient bits}
                tmp  = acc_step[2*WIDTH-1:WIDTH-1];
                diff = tmp - {1'b0, b_q};
                if (!diff[WIDTH]) begin
                    acc_step = {diff[WIDTH-1:0], acc_step[WIDTH-2:0], 1'b1};
                end else begin
                    acc_step = {tmp[WIDTH-1:0], acc_step[WIDTH-2:0], 1'b0};
                end
            end else begin
                // acc = {partial product, multiplier bits not yet consumed}
                sum = {1'b0, acc_step[2*WIDTH-1:WIDTH]}
                    + (acc_step[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
                acc_step = {sum, acc_step[WIDTH-1:1]};
            end
        end
    end

    // Sign restoration applied on the closing FIXUP edge
    always_comb begin
        prod_fix = neg_q ? -acc_q : acc_q;
        quo_fix  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    // Next-state and datapath control
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        a_d       = a_q;
        b_d       = b_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                // flush also blocks a same-cycle start, including MTHI/MTLO
                if (start && !flush) begin
                    if (op_mul || op_div) begin
                        a_d       = op_div ? src_a : abs_a;
                        b_d       = abs_b;
                        acc_d     = {{WIDTH{1'b0}}, (op_div ? abs_a : abs_b)};
                        cnt_d     = '0;
                        is_div_d  = op_div;
                        neg_d     = op_signed && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                        rem_neg_d = op_signed && src_a[WIDTH-1];
                        state_d   = StRun;
                    end else if (alucontrol == OP_MTHI) begin
                        hi_d = src_a;
                    end else if (alucontrol == OP_MTLO) begin
                        lo_d = src_a;
                    end
                end
            end
            StRun: begin
                if (flush) begin
                    state_d = StIdle;
                end else begin
                    acc_d = acc_step;
                    cnt_d = cnt_q + CNTW'(1);
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = StFixup;
                    end
                end
            end
            StFixup: begin
                state_d = StIdle;
                if (!flush) begin
                    done_d = 1'b1;
                    if (!is_div_q) begin
                        {hi_d, lo_d} = prod_fix;
                    end else if (b_q == '0) begin
                        hi_d = a_q;
                        lo_d = '1;
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            acc_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            a_q       <= a_d;
            b_q       <= b_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign busy = (state_q != StIdle);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
